// File: rtl/uart_fifo_flagged_if.sv
// Bus-side bundle for uart_fifo_flagged: push/pop handshake, data and status flags.
//   master : producer/consumer side (drives Write/WriteData/Read/ClearErr)
//   slave  : FIFO side (drives ReadData, ReadValid, Count and all status flags)
interface uart_fifo_flagged_if #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned ADDR_BITS = 4
);
    logic                 Write;
    logic [WIDTH-1:0]     WriteData;
    logic                 Read;
    logic                 ClearErr;
    logic [WIDTH-1:0]     ReadData;
    logic                 ReadValid;
    logic                 Empty;
    logic                 Full;
    logic                 AlmostFull;
    logic                 AlmostEmpty;
    logic [ADDR_BITS:0]   Count;
    logic                 Overflow;
    logic                 Underflow;

    modport master (
        output Write, WriteData, Read, ClearErr,
        input  ReadData, ReadValid, Empty, Full, AlmostFull, AlmostEmpty,
               Count, Overflow, Underflow
    );

    modport slave (
        input  Write, WriteData, Read, ClearErr,
        output ReadData, ReadValid, Empty, Full, AlmostFull, AlmostEmpty,
               Count, Overflow, Underflow
    );
endinterface

// File: rtl/uart_fifo_flagged.sv
// Synchronous byte FIFO between the UART baud-rate datapath and the bus side.
// Occupancy count, almost-full/almost-empty thresholds, FWFT or registered read,
// sticky overflow/underflow flags with synchronous clear.
//   Clock  : rising-edge clock
//   ResetN : asynchronous active-low reset
//   bus    : slave side of uart_fifo_flagged_if (handshake, data, status)
module uart_fifo_flagged #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned ADDR_BITS  = 4,
    parameter int unsigned AFULL_LVL  = 14,
    parameter int unsigned AEMPTY_LVL = 2,
    parameter int unsigned FWFT       = 1
) (
    input  logic                Clock,
    input  logic                ResetN,
    uart_fifo_flagged_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << ADDR_BITS;
    localparam int unsigned CW    = ADDR_BITS + 1;

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 empty_q, empty_d;
    logic                 full_q, full_d;
    logic                 afull_q, afull_d;
    logic                 aempty_q, aempty_d;
    logic                 ovf_q, ovf_d;
    logic                 udf_q, udf_d;
    logic                 rd_ok_c, wr_ok_c;

    // Accept decisions and next state; Count alone decides full/empty.
    always_comb begin
        rd_ok_c  = bus.Read & ~empty_q;
        // A push at full is only taken when a pop frees the slot the same cycle.
        wr_ok_c  = bus.Write & (~full_q | bus.Read);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_ok_c) wr_ptr_d = wr_ptr_q + ADDR_BITS'(1);
        if (rd_ok_c) rd_ptr_d = rd_ptr_q + ADDR_BITS'(1);

        count_d  = count_q + CW'(wr_ok_c) - CW'(rd_ok_c);
        empty_d  = (count_d == CW'(0));
        full_d   = (count_d == CW'(DEPTH));
        afull_d  = (count_d >= CW'(AFULL_LVL));
        aempty_d = (count_d <= CW'(AEMPTY_LVL));

        // A fresh error outranks a clear in the same cycle.
        ovf_d = ovf_q;
        if (bus.ClearErr)             ovf_d = 1'b0;
        if (bus.Write & ~wr_ok_c)     ovf_d = 1'b1;
        udf_d = udf_q;
        if (bus.ClearErr)             udf_d = 1'b0;
        if (bus.Read & ~rd_ok_c)      udf_d = 1'b1;
    end

    // Control and status registers.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage array, intentionally not reset.
    always_ff @(posedge Clock) begin
        if (wr_ok_c) mem[wr_ptr_q] <= bus.WriteData;
    end

    assign bus.Count       = count_q;
    assign bus.Empty       = empty_q;
    assign bus.Full        = full_q;
    assign bus.AlmostFull  = afull_q;
    assign bus.AlmostEmpty = aempty_q;
    assign bus.Overflow    = ovf_q;
    assign bus.Underflow   = udf_q;

    if (FWFT != 0) begin : g_fwft
        // Head word presented straight from the array.
        assign bus.ReadData  = mem[rd_ptr_q];
        assign bus.ReadValid = ~empty_q;
    end else begin : g_regrd
        logic [WIDTH-1:0] rdata_q;
        logic             rvalid_q;

        // Popped word captured at the edge; held until the next pop.
        always_ff @(posedge Clock or negedge ResetN) begin
            if (!ResetN) begin
                rdata_q  <= '0;
                rvalid_q <= 1'b0;
            end else begin
                rvalid_q <= rd_ok_c;
                if (rd_ok_c) rdata_q <= mem[rd_ptr_q];
            end
        end

        assign bus.ReadData  = rdata_q;
        assign bus.ReadValid = rvalid_q;
    end
endmodule

// File: tb/tb_uart_fifo_flagged.sv
// Drives an FWFT and a registered-read FIFO with identical stimulus and compares
// both against a queue-based reference model after every clock edge.
module tb_uart_fifo_flagged;
    localparam int unsigned DEPTH = 16;

    logic Clock;
    logic ResetN;

    uart_fifo_flagged_if #(.WIDTH(8), .ADDR_BITS(4)) f1 ();
    uart_fifo_flagged_if #(.WIDTH(8), .ADDR_BITS(4)) f0 ();

    uart_fifo_flagged #(.WIDTH(8), .ADDR_BITS(4), .AFULL_LVL(14), .AEMPTY_LVL(2), .FWFT(1)) dut_fwft (
        .Clock (Clock),
        .ResetN(ResetN),
        .bus   (f1)
    );

    uart_fifo_flagged #(.WIDTH(8), .ADDR_BITS(4), .AFULL_LVL(14), .AEMPTY_LVL(2), .FWFT(0)) dut_reg (
        .Clock (Clock),
        .ResetN(ResetN),
        .bus   (f0)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model
    bit [7:0] q[$];
    bit       ovf_m, udf_m, rv_m;
    bit [7:0] last_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        ovf_m  = 1'b0;
        udf_m  = 1'b0;
        rv_m   = 1'b0;
        last_m = 8'h00;
    endtask

    task automatic check_all(input string step);
        int n;
        n = q.size();
        check({step, ":cnt1"},    32'(f1.Count),       32'(n));
        check({step, ":empty1"},  32'(f1.Empty),       32'(n == 0));
        check({step, ":full1"},   32'(f1.Full),        32'(n == DEPTH));
        check({step, ":afull1"},  32'(f1.AlmostFull),  32'(n >= 14));
        check({step, ":aempty1"}, 32'(f1.AlmostEmpty), 32'(n <= 2));
        check({step, ":ovf1"},    32'(f1.Overflow),    32'(ovf_m));
        check({step, ":udf1"},    32'(f1.Underflow),   32'(udf_m));
        check({step, ":rv1"},     32'(f1.ReadValid),   32'(n != 0));
        if (n != 0) check({step, ":head1"}, 32'(f1.ReadData), 32'(q[0]));
        check({step, ":cnt0"},    32'(f0.Count),       32'(n));
        check({step, ":ovf0"},    32'(f0.Overflow),    32'(ovf_m));
        check({step, ":udf0"},    32'(f0.Underflow),   32'(udf_m));
        check({step, ":rv0"},     32'(f0.ReadValid),   32'(rv_m));
        check({step, ":rd0"},     32'(f0.ReadData),    32'(last_m));
    endtask

    task automatic drive(input bit wr, input bit [7:0] wd, input bit rd, input bit clr);
        f1.Write = wr; f1.WriteData = wd; f1.Read = rd; f1.ClearErr = clr;
        f0.Write = wr; f0.WriteData = wd; f0.Read = rd; f0.ClearErr = clr;
    endtask

    // One clock: apply inputs, advance the model, check just after the edge.
    task automatic cycle(input string step, input bit wr, input bit [7:0] wd, input bit rd, input bit clr);
        int  n;
        bit  rd_ok, wr_ok;
        drive(wr, wd, rd, clr);
        n     = q.size();
        rd_ok = rd && (n != 0);
        wr_ok = wr && ((n != DEPTH) || rd);
        rv_m  = rd_ok;
        if (rd_ok) last_m = q.pop_front();
        if (wr_ok) q.push_back(wd);
        if (wr && !wr_ok) ovf_m = 1'b1; else if (clr) ovf_m = 1'b0;
        if (rd && !rd_ok) udf_m = 1'b1; else if (clr) udf_m = 1'b0;
        @(posedge Clock);
        #1;
        check_all(step);
    endtask

    task automatic drain(input string step);
        while (q.size() != 0) cycle(step, 1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        ResetN = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        model_reset();
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        ResetN = 1'b1;
        #1;
        check_all("reset");

        // T1: asynchronous reset mid-cycle with 5 entries held
        for (int i = 0; i < 5; i++) cycle("t1fill", 1'b1, 8'($urandom), 1'b0, 1'b0);
        cycle("t1rd", 1'b0, 8'h00, 1'b1, 1'b0);
        cycle("t1wr", 1'b1, 8'h3C, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        @(posedge Clock);
        #3;
        ResetN = 1'b0;
        #1;
        model_reset();
        check_all("t1async");
        @(negedge Clock);
        ResetN = 1'b1;

        // T2: fill with 0x00..0x0F, drain in order
        for (int i = 0; i < 16; i++) cycle("t2fill", 1'b1, 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) cycle("t2drain", 1'b0, 8'h00, 1'b1, 1'b0);

        // T3: rejected write at full, then clear
        for (int i = 0; i < 16; i++) cycle("t3fill", 1'b1, 8'($urandom_range(0, 8'hA9)), 1'b0, 1'b0);
        cycle("t3ovf", 1'b1, 8'hAA, 1'b0, 1'b0);
        cycle("t3idle", 1'b0, 8'h00, 1'b0, 1'b0);
        drain("t3drain");
        cycle("t3clr", 1'b0, 8'h00, 1'b0, 1'b1);
        // new error in the same cycle as a clear keeps the flag set
        cycle("t3udf", 1'b0, 8'h00, 1'b1, 1'b1);
        cycle("t3udfhold", 1'b0, 8'h00, 1'b0, 1'b0);
        cycle("t3clr2", 1'b0, 8'h00, 1'b0, 1'b1);

        // T4: simultaneous push/pop at full and at empty
        for (int i = 0; i < 16; i++) cycle("t4fill", 1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        cycle("t4full_rw", 1'b1, 8'h55, 1'b1, 1'b0);
        drain("t4drain");
        cycle("t4empty_rw", 1'b1, 8'h77, 1'b1, 1'b0);
        cycle("t4clr", 1'b0, 8'h00, 1'b0, 1'b1);

        // T5: random interleaved traffic wrapping the pointers
        for (int i = 0; i < 80; i++) begin
            cycle("t5rand", 1'($urandom_range(0, 9) < 7), 8'($urandom),
                  1'($urandom_range(0, 9) < 5), 1'($urandom_range(0, 15) == 0));
        end
        drain("t5drain");
        cycle("t5clr", 1'b0, 8'h00, 1'b0, 1'b1);

        // T6: registered-read latency and hold
        cycle("t6w1", 1'b1, 8'h11, 1'b0, 1'b0);
        cycle("t6w2", 1'b1, 8'h22, 1'b0, 1'b0);
        cycle("t6rd", 1'b0, 8'h00, 1'b1, 1'b0);
        check("t6rv_pulse", 32'(f0.ReadValid), 32'd1);
        check("t6rd_data",  32'(f0.ReadData),  32'h11);
        cycle("t6idle", 1'b0, 8'h00, 1'b0, 1'b0);
        check("t6rv_low",   32'(f0.ReadValid), 32'd0);
        check("t6rd_hold",  32'(f0.ReadData),  32'h11);
        drain("t6drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
